// File: rtl/song_frame_sequencer.sv
// Steps through song ROM one frame at a time, fetching CHANNELS (freq, amp) word pairs per frame
// and presenting them atomically to the signal generators at a fixed frame rate.
module song_frame_sequencer #(
   parameter int CHANNELS    = 3,
   parameter int ADDR_W      = 16,
   parameter int FRAME_COUNT = 184,
   parameter int FRAME_MS    = 50,
   parameter int CLK_PER_MS  = 50000,
   parameter int ROM_LATENCY = 1
) (
   input  logic                     clock_50Mhz,
   input  logic                     reset_n,
   input  logic                     enable,
   output logic [ADDR_W-1:0]        romIndex,
   input  logic [15:0]              romDataInput,
   output logic [CHANNELS*14-1:0]   channelFrequency,
   output logic [CHANNELS*8-1:0]    channelAmplitude,
   output logic                     frameValid,
   output logic                     outputActive,
   output logic [ADDR_W-1:0]        currentFrame,
   output logic                     stateComplete
);
   localparam int WORDS = 2 * CHANNELS;
   localparam int CW    = $clog2(WORDS + ROM_LATENCY + 1);
   localparam int PW    = $clog2(CLK_PER_MS + 1);
   localparam int MW    = $clog2(FRAME_MS + 1);

   if (FRAME_COUNT * 2 * CHANNELS > 2 ** ADDR_W) begin : g_rom_range_check
      $error("song_frame_sequencer: song does not fit in ROM address space");
   end

   typedef enum logic [1:0] {IDLE, FETCH, WAIT, DONE} state_t;
   state_t state, state_nxt;

   logic [CW-1:0]              cnt;
   logic [CW-1:0]              widx;
   logic [PW-1:0]              pre;
   logic [MW-1:0]              ms;
   logic [CHANNELS*14-1:0]     shadow_freq, shadow_freq_nxt;
   logic [CHANNELS*8-1:0]      shadow_amp, shadow_amp_nxt;
   logic [ADDR_W-1:0]          frame_new, base_new;
   logic                       period_end, last_frame, fetch_last;
   logic                       start_fetch, enter_done;
   logic                       unused_bits;

   assign unused_bits  = &{1'b0, romDataInput[15:14]};
   assign period_end   = (pre == PW'(CLK_PER_MS - 1)) && (ms == MW'(FRAME_MS - 1));
   assign last_frame   = (currentFrame == ADDR_W'(FRAME_COUNT - 1));
   assign fetch_last   = (state == FETCH) && (cnt == CW'(WORDS + ROM_LATENCY - 1));
   assign frame_new    = (state == IDLE) ? '0 : currentFrame + 1'b1;
   assign base_new     = frame_new * ADDR_W'(WORDS);
   assign widx         = cnt - CW'(ROM_LATENCY);
   assign outputActive = (state == FETCH) || (state == WAIT);
   assign stateComplete = (state == DONE);

   always_ff @(posedge clock_50Mhz or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      start_fetch = 1'b0;
      enter_done  = 1'b0;
      if (!enable) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               state_nxt   = FETCH;
               start_fetch = 1'b1;
            end
            FETCH: if (fetch_last) state_nxt = WAIT;
            WAIT: begin
               if (period_end) begin
                  if (last_frame) begin
                     state_nxt  = DONE;
                     enter_done = 1'b1;
                  end else begin
                     state_nxt   = FETCH;
                     start_fetch = 1'b1;
                  end
               end
            end
            default: state_nxt = state;
         endcase
      end
   end

   // Word k of the frame arrives ROM_LATENCY cycles after its address was presented.
   always_comb begin
      shadow_freq_nxt = shadow_freq;
      shadow_amp_nxt  = shadow_amp;
      if (state == FETCH && cnt >= CW'(ROM_LATENCY)) begin
         for (int k = 0; k < CHANNELS; k++) begin
            if (widx == CW'(2 * k))     shadow_freq_nxt[14*k +: 14] = romDataInput[13:0];
            if (widx == CW'(2 * k + 1)) shadow_amp_nxt[8*k +: 8]    = romDataInput[7:0];
         end
      end
   end

   always_ff @(posedge clock_50Mhz or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0; pre <= '0; ms <= '0;
         romIndex <= '0; currentFrame <= '0;
         shadow_freq <= '0; shadow_amp <= '0;
         channelFrequency <= '0; channelAmplitude <= '0; frameValid <= 1'b0;
      end else if (!enable) begin
         cnt <= '0; pre <= '0; ms <= '0;
         romIndex <= '0; currentFrame <= '0;
         shadow_freq <= '0; shadow_amp <= '0;
         channelFrequency <= '0; channelAmplitude <= '0; frameValid <= 1'b0;
      end else begin
         frameValid  <= 1'b0;
         shadow_freq <= shadow_freq_nxt;
         shadow_amp  <= shadow_amp_nxt;
         if (start_fetch) begin
            cnt <= '0; pre <= '0; ms <= '0;
            currentFrame <= frame_new;
            romIndex     <= base_new;
         end else begin
            if (state == FETCH || state == WAIT) begin
               if (pre == PW'(CLK_PER_MS - 1)) begin
                  pre <= '0;
                  ms  <= (ms == MW'(FRAME_MS - 1)) ? '0 : ms + 1'b1;
               end else begin
                  pre <= pre + 1'b1;
               end
            end
            if (state == FETCH) begin
               cnt <= cnt + 1'b1;
               if (cnt < CW'(WORDS - 1)) romIndex <= romIndex + 1'b1;
               // Last word bypasses the shadow so the whole frame lands in one edge.
               if (fetch_last) begin
                  channelFrequency <= shadow_freq_nxt;
                  channelAmplitude <= shadow_amp_nxt;
                  frameValid       <= 1'b1;
               end
            end
            if (enter_done) channelAmplitude <= '0;
         end
      end
   end
endmodule

// File: tb/tb_song_frame_sequencer.sv
// Bench for song_frame_sequencer: checkpoint table over a full song plus abort and reset sequences.
`timescale 1ns/1ps
module tb_song_frame_sequencer;
   localparam int C = 3, AW = 16, FC = 3, FMS = 2, CPM = 10, L = 1;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            enable = 1'b0;
   logic [AW-1:0]   rom_idx, cur_frame;
   logic [15:0]     rom_q = 16'd0;
   logic [C*14-1:0] freq;
   logic [C*8-1:0]  amp;
   logic            fv, active, complete;

   int total = 0, bad = 0, cyc = 0;

   typedef struct { int cyc; int frame; } sb_t;
   sb_t sb[$];

   typedef struct {
      int              cyc;
      logic [15:0]     rom;
      logic            act;
      logic            comp;
      logic [15:0]     frame;
      logic [C*14-1:0] freq;
      logic [C*8-1:0]  amp;
   } vec_t;
   vec_t tbl[$];

   always #5 clk = ~clk;
   always @(posedge clk) rom_q <= rom_idx + 16'd1;

   song_frame_sequencer #(
      .CHANNELS(C), .ADDR_W(AW), .FRAME_COUNT(FC), .FRAME_MS(FMS),
      .CLK_PER_MS(CPM), .ROM_LATENCY(L)
   ) dut (
      .clock_50Mhz(clk), .reset_n(rst_n), .enable(enable),
      .romIndex(rom_idx), .romDataInput(rom_q),
      .channelFrequency(freq), .channelAmplitude(amp),
      .frameValid(fv), .outputActive(active),
      .currentFrame(cur_frame), .stateComplete(complete)
   );

   function automatic logic [C*14-1:0] ffreq(int f);
      logic [C*14-1:0] r;
      for (int k = 0; k < C; k++) r[14*k +: 14] = 14'(6*f + 2*k + 1);
      return r;
   endfunction

   function automatic logic [C*8-1:0] famp(int f);
      logic [C*8-1:0] r;
      for (int k = 0; k < C; k++) r[8*k +: 8] = 8'(6*f + 2*k + 2);
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
      total++;
      if (act_v !== exp_v) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act_v, exp_v);
      end
   endtask

   task automatic step();
      sb_t e;
      @(posedge clk);
      #1;
      cyc++;
      if (fv === 1'b1) begin
         if (sb.size() == 0) begin
            chk("fv_unexpected", 64'(fv), 64'd0);
         end else begin
            e = sb.pop_front();
            chk("fv_cycle", 64'(cyc), 64'(e.cyc));
            chk("fv_freq", 64'(freq), 64'(ffreq(e.frame)));
            chk("fv_amp", 64'(amp), 64'(famp(e.frame)));
            chk("fv_frame", 64'(cur_frame), 64'(e.frame));
            chk("fv_active", 64'(active), 64'd1);
         end
      end
   endtask

   task automatic check_zero(input string name);
      chk({name, "_rom"}, 64'(rom_idx), 64'd0);
      chk({name, "_freq"}, 64'(freq), 64'd0);
      chk({name, "_amp"}, 64'(amp), 64'd0);
      chk({name, "_fv"}, 64'(fv), 64'd0);
      chk({name, "_act"}, 64'(active), 64'd0);
      chk({name, "_frame"}, 64'(cur_frame), 64'd0);
      chk({name, "_comp"}, 64'(complete), 64'd0);
   endtask

   task automatic add(input int c, input int rom, input logic a, input logic cp, input int fr,
                      input logic [C*14-1:0] fq, input logic [C*8-1:0] am);
      vec_t v;
      v.cyc = c; v.rom = 16'(rom); v.act = a; v.comp = cp; v.frame = 16'(fr);
      v.freq = fq; v.amp = am;
      tbl.push_back(v);
   endtask

   initial begin
      int idx;
      add(0,   0,  1'b1, 1'b0, 0, '0,       '0);
      add(5,   5,  1'b1, 1'b0, 0, '0,       '0);
      add(6,   5,  1'b1, 1'b0, 0, '0,       '0);
      add(7,   5,  1'b1, 1'b0, 0, ffreq(0), famp(0));
      add(19,  5,  1'b1, 1'b0, 0, ffreq(0), famp(0));
      add(20,  6,  1'b1, 1'b0, 1, ffreq(0), famp(0));
      add(26,  11, 1'b1, 1'b0, 1, ffreq(0), famp(0));
      add(27,  11, 1'b1, 1'b0, 1, ffreq(1), famp(1));
      add(40,  12, 1'b1, 1'b0, 2, ffreq(1), famp(1));
      add(47,  17, 1'b1, 1'b0, 2, ffreq(2), famp(2));
      add(59,  17, 1'b1, 1'b0, 2, ffreq(2), famp(2));
      add(60,  17, 1'b0, 1'b1, 2, ffreq(2), '0);
      add(160, 17, 1'b0, 1'b1, 2, ffreq(2), '0);

      // Reset, then idle with enable low.
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      @(negedge clk) rst_n = 1'b1;
      repeat (20) step();
      check_zero("idle20");

      // Full song.
      sb.push_back('{7, 0});
      sb.push_back('{27, 1});
      sb.push_back('{47, 2});
      enable = 1'b1;
      cyc = -1;
      idx = 0;
      while (cyc < 165) begin
         step();
         if (cyc <= 5) chk("fetch0_rom", 64'(rom_idx), 64'(cyc));
         if (cyc >= 20 && cyc <= 25) chk("fetch1_rom", 64'(rom_idx), 64'(cyc - 14));
         if (cyc >= 20 && cyc <= 26) chk("hold_old_freq", 64'(freq), 64'(ffreq(0)));
         while (idx < tbl.size() && tbl[idx].cyc == cyc) begin
            chk("tbl_rom", 64'(rom_idx), 64'(tbl[idx].rom));
            chk("tbl_act", 64'(active), 64'(tbl[idx].act));
            chk("tbl_comp", 64'(complete), 64'(tbl[idx].comp));
            chk("tbl_frame", 64'(cur_frame), 64'(tbl[idx].frame));
            chk("tbl_freq", 64'(freq), 64'(tbl[idx].freq));
            chk("tbl_amp", 64'(amp), 64'(tbl[idx].amp));
            idx++;
         end
      end
      chk("song_sb_empty", 64'(sb.size()), 64'd0);
      chk("song_tbl_done", 64'(idx), 64'(tbl.size()));
      enable = 1'b0;
      step();
      check_zero("done_disable");

      // Abort during a fetch.
      enable = 1'b1;
      cyc = -1;
      step();
      chk("abort_rom0", 64'(rom_idx), 64'd0);
      repeat (3) step();
      chk("abort_rom3", 64'(rom_idx), 64'd3);
      enable = 1'b0;
      step();
      check_zero("abort");
      repeat (10) step();
      check_zero("abort_idle");

      // Re-enable restarts at frame 0.
      sb.push_back('{7, 0});
      sb.push_back('{27, 1});
      enable = 1'b1;
      cyc = -1;
      step();
      chk("reen_rom", 64'(rom_idx), 64'd0);
      repeat (8) step();
      chk("reen_sb", 64'(sb.size()), 64'd1);

      // Async reset mid-WAIT of frame 1.
      while (cyc < 32) step();
      chk("pre_rst_frame", 64'(cur_frame), 64'd1);
      chk("pre_rst_sb", 64'(sb.size()), 64'd0);
      rst_n = 1'b0;
      #2;
      check_zero("async_rst");
      @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      sb.push_back('{7, 0});
      cyc = -1;
      step();
      chk("rst_restart_rom", 64'(rom_idx), 64'd0);
      chk("rst_restart_frame", 64'(cur_frame), 64'd0);
      chk("rst_restart_act", 64'(active), 64'd1);
      repeat (8) step();
      chk("rst_restart_sb", 64'(sb.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
